register_file: RTL

//  Architectural register file with rename tags: 32 x 32-bit values plus one dependency tag per reg.

---
 rtl/cpu_defs_pkg.sv | 21 ++
 rtl/rf_read_port.sv | 42 ++++
 rtl/register_file.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared widths, sentinel codes and rename-tag type for the register file and its read ports.
package cpu_defs_pkg;

    localparam int unsigned REG_WIDTH    = 5;
    localparam int unsigned EX_REG_WIDTH = 6;
    localparam int unsigned RoB_WIDTH    = 8;
    localparam int unsigned EX_RoB_WIDTH = 9;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned NUM_REGS     = 32;

    localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'h20;
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'h100;

    typedef logic [EX_RoB_WIDTH-1:0] tag_t;

    // A live tag is the RoB index with the "no dependency" MSB clear.
    function automatic tag_t make_tag(input logic [RoB_WIDTH-1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// Combinational register-file read port: tag/value lookup, x0 and flush overrides,
// plus a same-cycle commit bypass when RF_COMMIT_BYPASS_EN is defined.
module rf_read_port
    import cpu_defs_pkg::*;
(
    input  logic [REG_WIDTH-1:0]                 rs,
    input  tag_t [NUM_REGS-1:0]                  tags,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  values,
    input  logic                                 flush,
    input  logic                                 commit_en,
    input  logic [EX_REG_WIDTH-1:0]              commit_rd,
    input  logic [RoB_WIDTH-1:0]                 commit_idx,
    input  logic [DATA_WIDTH-1:0]                commit_value,
    output tag_t                                 q,
    output logic [DATA_WIDTH-1:0]                v
);

`ifndef RF_COMMIT_BYPASS_EN
    logic unused_commit;
    assign unused_commit = ^{commit_en, commit_rd, commit_idx, commit_value};
`endif

    always_comb begin
        q = tags[rs];
        v = values[rs];
`ifdef RF_COMMIT_BYPASS_EN
        if (commit_en && (commit_rd == {1'b0, rs}) && (tags[rs] == make_tag(commit_idx))) begin
            q = NON_DEP;
            v = commit_value;
        end
`endif
        if (rs == '0) begin
            q = NON_DEP;
            v = '0;
        end
        // A flushing cycle has no outstanding producers left to wait on.
        if (flush) begin
            q = NON_DEP;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (x1..x31; x0 is hard-wired).
// Optional RF_COMMIT_BYPASS_EN forwards a same-cycle commit to the read ports.
module register_file
    import cpu_defs_pkg::*;
(
    input  logic                     Sys_clk,
    input  logic                     Sys_rst_n,
    input  logic                     Sys_rdy,
    input  logic                     RoBRF_pre_judge,
    input  logic                     RoBRF_en,
    input  logic [RoB_WIDTH-1:0]     RoBRF_RoB_index,
    input  logic [EX_REG_WIDTH-1:0]  RoBRF_rd,
    input  logic [DATA_WIDTH-1:0]    RoBRF_value,
    input  logic [REG_WIDTH-1:0]     DPRF_rs1,
    input  logic [REG_WIDTH-1:0]     DPRF_rs2,
    input  logic                     DPRF_en,
    input  logic [EX_REG_WIDTH-1:0]  DPRF_rd,
    input  logic [RoB_WIDTH-1:0]     DPRF_RoB_index,
    output tag_t                     RFDP_Qj,
    output tag_t                     RFDP_Qk,
    output logic [DATA_WIDTH-1:0]    RFDP_Vj,
    output logic [DATA_WIDTH-1:0]    RFDP_Vk
);

    tag_t [NUM_REGS-1:0]                  tag_bus;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  value_bus;
    logic                                 flush;

    assign flush = ~RoBRF_pre_judge;

    assign tag_bus[0]   = NON_DEP;
    assign value_bus[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        tag_t                   tag_r;
        logic [DATA_WIDTH-1:0]  value_r;
        logic                   commit_sel;
        logic                   rename_sel;

        assign commit_sel = RoBRF_en && (RoBRF_rd == EX_REG_WIDTH'(g));
        assign rename_sel = DPRF_en  && (DPRF_rd  == EX_REG_WIDTH'(g));

        // Priority on the tag: reset > flush > rename > matching commit clears.
        always_ff @(posedge Sys_clk) begin
            if (!Sys_rst_n) begin
                tag_r   <= NON_DEP;
                value_r <= '0;
            end else if (Sys_rdy) begin
                if (commit_sel) begin
                    value_r <= RoBRF_value;
                end
                if (flush) begin
                    tag_r <= NON_DEP;
                end else if (rename_sel) begin
                    tag_r <= make_tag(DPRF_RoB_index);
                end else if (commit_sel && (tag_r == make_tag(RoBRF_RoB_index))) begin
                    tag_r <= NON_DEP;
                end
            end
        end

        assign tag_bus[g]   = tag_r;
        assign value_bus[g] = value_r;
    end

    rf_read_port u_port_j (
        .rs           (DPRF_rs1),
        .tags         (tag_bus),
        .values       (value_bus),
        .flush        (flush),
        .commit_en    (RoBRF_en),
        .commit_rd    (RoBRF_rd),
        .commit_idx   (RoBRF_RoB_index),
        .commit_value (RoBRF_value),
        .q            (RFDP_Qj),
        .v            (RFDP_Vj)
    );

    rf_read_port u_port_k (
        .rs           (DPRF_rs2),
        .tags         (tag_bus),
        .values       (value_bus),
        .flush        (flush),
        .commit_en    (RoBRF_en),
        .commit_rd    (RoBRF_rd),
        .commit_idx   (RoBRF_RoB_index),
        .commit_value (RoBRF_value),
        .q            (RFDP_Qk),
        .v            (RFDP_Vk)
    );

endmodule
